// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage
// Brief   : MEM/WB pipeline register. Extracts loads, checks alignment,
//           selects write-back data and counts retired entries.
// Revision: 1.0
// ============================================================================
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic                      clk_MemWB,
  input  logic                      rst_MemWB,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [XLEN-1:0]           pc4_i,
  input  logic [RADDR_W-1:0]        rd_addr_i,
  input  logic [XLEN-1:0]           alu_i,
  input  logic [XLEN-1:0]           dmem_i,
  input  logic [2:0]                funct3_i,
  input  logic [$clog2(XLEN/8)-1:0] byte_off_i,
  input  logic [1:0]                memtoreg_i,
  input  logic                      regwrite_i,
  output logic                      valid_o,
  output logic [RADDR_W-1:0]        rd_addr_o,
  output logic                      regwrite_o,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      misalign_o,
  output logic [CNT_W-1:0]          retire_cnt_o
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  // --------------------------------------------------------------------------
  // Load extraction (before capture)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] shifted;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_word;
  logic [XLEN-1:0] load_ext;
  logic            load_legal;
  logic            ld_misalign;

  // Right-align the addressed lane so every access reads from bit 0.
  assign shifted = dmem_i >> {byte_off_i, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = shifted[15:0];
  assign ld_word = shifted[31:0];

  always_comb begin
    load_ext    = '0;
    load_legal  = 1'b1;
    ld_misalign = 1'b0;
    case (funct3_i)
      F3_LB: begin
        load_ext = XLEN'($signed(ld_byte));
      end
      F3_LBU: begin
        load_ext = XLEN'(ld_byte);
      end
      F3_LH: begin
        load_ext    = XLEN'($signed(ld_half));
        ld_misalign = byte_off_i[0];
      end
      F3_LHU: begin
        load_ext    = XLEN'(ld_half);
        ld_misalign = byte_off_i[0];
      end
      F3_LW: begin
        load_ext    = XLEN'($signed(ld_word));
        ld_misalign = |byte_off_i[1:0];
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          load_ext    = XLEN'(ld_word);
          ld_misalign = |byte_off_i[1:0];
        end else begin
          load_legal = 1'b0;
        end
      end
      F3_LD: begin
        if (XLEN == 64) begin
          load_ext    = shifted;
          ld_misalign = |byte_off_i;
        end else begin
          load_legal = 1'b0;
        end
      end
      default: begin
        load_legal = 1'b0;
      end
    endcase
  end

  logic            is_load;
  logic            misalign_cap;
  logic            regwrite_cap;
  logic [XLEN-1:0] load_cap;

  // Only loads can be misaligned or illegal; other selects ignore funct3/offset.
  assign is_load      = (memtoreg_i == SEL_LOAD);
  assign misalign_cap = is_load & load_legal & ld_misalign;
  assign regwrite_cap = regwrite_i & ~(is_load & (~load_legal | ld_misalign));
  assign load_cap     = load_legal ? load_ext : '0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic               valid_q,      valid_d;
  logic               regwrite_q,   regwrite_d;
  logic               misalign_q,   misalign_d;
  logic [RADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic [1:0]         memtoreg_q,   memtoreg_d;
  logic [XLEN-1:0]    pc4_q,        pc4_d;
  logic [XLEN-1:0]    alu_q,        alu_d;
  logic [XLEN-1:0]    load_q,       load_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    misalign_d   = misalign_q;
    rd_addr_d    = rd_addr_q;
    memtoreg_d   = memtoreg_q;
    pc4_d        = pc4_q;
    alu_d        = alu_q;
    load_d       = load_q;
    retire_cnt_d = retire_cnt_q;
    if (flush_i) begin
      // Flush outranks stall; payload fields are left as they were.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      misalign_d = 1'b0;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      regwrite_d = regwrite_cap;
      misalign_d = misalign_cap;
      rd_addr_d  = rd_addr_i;
      memtoreg_d = memtoreg_i;
      pc4_d      = pc4_i;
      alu_d      = alu_i;
      load_d     = load_cap;
      if (valid_i) begin
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_MemWB or posedge rst_MemWB) begin
    if (rst_MemWB) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      misalign_q   <= 1'b0;
      rd_addr_q    <= '0;
      memtoreg_q   <= SEL_ALU;
      pc4_q        <= '0;
      alu_q        <= '0;
      load_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      misalign_q   <= misalign_d;
      rd_addr_q    <= rd_addr_d;
      memtoreg_q   <= memtoreg_d;
      pc4_q        <= pc4_d;
      alu_q        <= alu_d;
      load_q       <= load_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    case (memtoreg_q)
      SEL_ALU:  wb_data_o = alu_q;
      SEL_LOAD: wb_data_o = load_q;
      SEL_PC4:  wb_data_o = pc4_q;
      default:  wb_data_o = '0;
    endcase
  end

  // Writes to x0 are dropped here so the register file need not special-case it.
  assign regwrite_o   = regwrite_q & valid_q & (rd_addr_q != '0);
  assign valid_o      = valid_q;
  assign rd_addr_o    = rd_addr_q;
  assign misalign_o   = misalign_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_stage
// Brief   : Directed self-checking bench for mem_wb_stage (XLEN=32), with a
//           second instance using a 4-bit retire counter for wrap checks.
// Revision: 1.0
// ============================================================================
module tb_mem_wb_stage;

  logic        clk_MemWB = 1'b0;
  logic        rst_MemWB;
  logic        stall_i, flush_i, valid_i, regwrite_i;
  logic [31:0] pc4_i, alu_i, dmem_i;
  logic [4:0]  rd_addr_i;
  logic [2:0]  funct3_i;
  logic [1:0]  byte_off_i, memtoreg_i;

  logic        valid_o, regwrite_o, misalign_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wb_data_o;
  logic [63:0] retire_cnt_o;

  logic        c4_valid, c4_regwrite, c4_misalign;
  logic [4:0]  c4_rd;
  logic [31:0] c4_wb;
  logic [3:0]  c4_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_MemWB = ~clk_MemWB;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
    .clk_MemWB(clk_MemWB), .rst_MemWB(rst_MemWB),
    .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc4_i(pc4_i), .rd_addr_i(rd_addr_i), .alu_i(alu_i), .dmem_i(dmem_i),
    .funct3_i(funct3_i), .byte_off_i(byte_off_i), .memtoreg_i(memtoreg_i),
    .regwrite_i(regwrite_i),
    .valid_o(valid_o), .rd_addr_o(rd_addr_o), .regwrite_o(regwrite_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o), .retire_cnt_o(retire_cnt_o)
  );

  mem_wb_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut_c4 (
    .clk_MemWB(clk_MemWB), .rst_MemWB(rst_MemWB),
    .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc4_i(pc4_i), .rd_addr_i(rd_addr_i), .alu_i(alu_i), .dmem_i(dmem_i),
    .funct3_i(funct3_i), .byte_off_i(byte_off_i), .memtoreg_i(memtoreg_i),
    .regwrite_i(regwrite_i),
    .valid_o(c4_valid), .rd_addr_o(c4_rd), .regwrite_o(c4_regwrite),
    .wb_data_o(c4_wb), .misalign_o(c4_misalign), .retire_cnt_o(c4_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] dmem,
                       input logic [31:0] alu, input logic [31:0] pc4);
    valid_i    = v;
    rd_addr_i  = rd;
    regwrite_i = rw;
    memtoreg_i = sel;
    funct3_i   = f3;
    byte_off_i = off;
    dmem_i     = dmem;
    alu_i      = alu;
    pc4_i      = pc4;
  endtask

  task automatic step();
    @(posedge clk_MemWB);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    64'(valid_o),    64'd0);
    check({tag, "_regwrite"}, 64'(regwrite_o), 64'd0);
    check({tag, "_misalign"}, 64'(misalign_o), 64'd0);
    check({tag, "_wb"},       64'(wb_data_o),  64'd0);
    check({tag, "_rd"},       64'(rd_addr_o),  64'd0);
    check({tag, "_cnt"},      retire_cnt_o,    64'd0);
    check({tag, "_cnt4"},     64'(c4_cnt),     64'd0);
  endtask

  localparam logic [31:0] WORD = 32'h80FF_7F01;

  initial begin
    rst_MemWB = 1'b1;
    stall_i   = 1'b0;
    flush_i   = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 2'b00, 3'b000, 2'd0, WORD, 32'hAAAA_5555, 32'h10);

    // Edges during reset must not capture anything.
    step();
    step();
    check_all_zero("in_reset");

    rst_MemWB = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 2'b01, 3'b000, 2'd3, WORD, 32'h0, 32'h0);
    step();
    check("lb_wb",       64'(wb_data_o),  64'hFFFF_FF80);
    check("lb_regwrite", 64'(regwrite_o), 64'd1);
    check("lb_rd",       64'(rd_addr_o),  64'd5);
    check("lb_valid",    64'(valid_o),    64'd1);
    check("lb_cnt",      retire_cnt_o,    64'd1);

    drive(1'b1, 5'd5, 1'b1, 2'b01, 3'b101, 2'd2, WORD, 32'h0, 32'h0);
    step();
    check("lhu_wb",  64'(wb_data_o), 64'h0000_80FF);
    check("lhu_cnt", retire_cnt_o,   64'd2);

    drive(1'b1, 5'd5, 1'b1, 2'b01, 3'b001, 2'd1, WORD, 32'h0, 32'h0);
    step();
    check("lh_mis_misalign", 64'(misalign_o), 64'd1);
    check("lh_mis_regwrite", 64'(regwrite_o), 64'd0);
    check("lh_mis_valid",    64'(valid_o),    64'd1);
    check("lh_mis_cnt",      retire_cnt_o,    64'd3);

    drive(1'b1, 5'd6, 1'b1, 2'b01, 3'b010, 2'd0, WORD, 32'h0, 32'h0);
    step();
    check("lw_wb",       64'(wb_data_o),  64'h80FF_7F01);
    check("lw_misalign", 64'(misalign_o), 64'd0);
    check("lw_regwrite", 64'(regwrite_o), 64'd1);

    drive(1'b1, 5'd6, 1'b1, 2'b01, 3'b010, 2'd2, WORD, 32'h0, 32'h0);
    step();
    check("lw_mis_misalign", 64'(misalign_o), 64'd1);
    check("lw_mis_regwrite", 64'(regwrite_o), 64'd0);

    drive(1'b1, 5'd6, 1'b1, 2'b01, 3'b100, 2'd3, WORD, 32'h0, 32'h0);
    step();
    check("lbu_wb", 64'(wb_data_o), 64'h0000_0080);

    drive(1'b1, 5'd6, 1'b1, 2'b01, 3'b001, 2'd2, WORD, 32'h0, 32'h0);
    step();
    check("lh_wb",       64'(wb_data_o),  64'hFFFF_80FF);
    check("lh_regwrite", 64'(regwrite_o), 64'd1);

    // LD is undefined at XLEN=32.
    drive(1'b1, 5'd6, 1'b1, 2'b01, 3'b011, 2'd0, WORD, 32'h0, 32'h0);
    step();
    check("undef_wb",       64'(wb_data_o),  64'd0);
    check("undef_regwrite", 64'(regwrite_o), 64'd0);
    check("undef_misalign", 64'(misalign_o), 64'd0);
    check("undef_cnt",      retire_cnt_o,    64'd8);

    // ALU select with a misaligned-looking funct3/offset pair.
    drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b001, 2'd1, WORD, 32'hDEAD_BEEF, 32'h0);
    step();
    check("alu_wb",       64'(wb_data_o),  64'hDEAD_BEEF);
    check("alu_misalign", 64'(misalign_o), 64'd0);
    check("alu_regwrite", 64'(regwrite_o), 64'd1);
    check("alu_cnt",      retire_cnt_o,    64'd9);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + i), 1'b0, 2'b10, 3'b000, 2'(i), 32'h1111_0000 + 32'(i),
            32'h2222_0000 + 32'(i), 32'h3333_0000 + 32'(i));
      step();
      check("stall_wb",       64'(wb_data_o),  64'hDEAD_BEEF);
      check("stall_rd",       64'(rd_addr_o),  64'd5);
      check("stall_regwrite", 64'(regwrite_o), 64'd1);
      check("stall_valid",    64'(valid_o),    64'd1);
      check("stall_cnt",      retire_cnt_o,    64'd9);
    end

    flush_i = 1'b1;
    step();
    check("sflush_valid",    64'(valid_o),    64'd0);
    check("sflush_regwrite", 64'(regwrite_o), 64'd0);
    check("sflush_cnt",      retire_cnt_o,    64'd9);
    stall_i = 1'b0;
    flush_i = 1'b0;

    drive(1'b1, 5'd0, 1'b1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0000_1004);
    step();
    check("x0_wb",       64'(wb_data_o),  64'h0000_1004);
    check("x0_regwrite", 64'(regwrite_o), 64'd0);
    check("x0_valid",    64'(valid_o),    64'd1);
    check("x0_cnt",      retire_cnt_o,    64'd10);

    drive(1'b1, 5'd3, 1'b1, 2'b11, 3'b000, 2'd0, WORD, 32'h5, 32'h9);
    step();
    check("zero_sel_wb",       64'(wb_data_o),  64'd0);
    check("zero_sel_regwrite", 64'(regwrite_o), 64'd1);

    flush_i = 1'b1;
    step();
    check("flush_valid",    64'(valid_o),    64'd0);
    check("flush_regwrite", 64'(regwrite_o), 64'd0);
    check("flush_cnt",      retire_cnt_o,    64'd11);
    flush_i = 1'b0;

    // Asynchronous reset mid-stall, between edges.
    stall_i = 1'b1;
    #3;
    rst_MemWB = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    stall_i   = 1'b0;
    rst_MemWB = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'd1, 1'b1, 2'b00, 3'b000, 2'd0, 32'h0, 32'(i), 32'h0);
      step();
    end
    check("wrap_cnt4", 64'(c4_cnt),  64'd1);
    check("wrap_cnt",  retire_cnt_o, 64'd17);

    #2;
    rst_MemWB = 1'b1;
    #1;
    check_all_zero("rst2");
    step();
    rst_MemWB = 1'b0;
    drive(1'b1, 5'd2, 1'b1, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0000_1234, 32'h0);
    step();
    check("post_rst_wb",  64'(wb_data_o), 64'h0000_1234);
    check("post_rst_cnt", retire_cnt_o,   64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
